mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_wait_counter.sv | 29 ++
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the IF/MEM SRAM arbiter: FSM states, grant identifiers
// and the wait-counter width.
package mem_arbiter_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_IF  = 1'b0,
        GRANT_MEM = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_arbiter_wait_counter.sv
// Loadable down-counter that times one SRAM access; zero marks the last
// ACCESS cycle.
module wait_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (IF read port, MEM read/write port) arbiter for a single
// multi-cycle SRAM; every output is decoded from registered state.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_ready,
    output logic [31:0]       rdata,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    localparam logic [CNT_W-1:0] LOAD_VALUE = CNT_W'(WAIT_CYCLES - 1);

    state_t            state;
    state_t            state_next;
    grant_t            grant_q;
    grant_t            last_grant;
    grant_t            pick;
    logic              any_req;
    logic              start;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_zero;

    // On a tie the requester that did not win last time goes first.
    assign any_req = if_req || mem_req;
    assign pick    = (mem_req && (!if_req || last_grant == GRANT_IF)) ? GRANT_MEM : GRANT_IF;
    assign start   = (state == ST_IDLE) && any_req;

    wait_counter #(
        .W(CNT_W)
    ) u_wait_counter (
        .clk       (clk),
        .rst       (rst),
        .load      (start),
        .load_value(LOAD_VALUE),
        .dec       (state == ST_ACCESS),
        .count     (cnt),
        .zero      (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:   if (any_req) state_next = ST_ACCESS;
            ST_ACCESS: if (cnt_zero) state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if_ready   = 1'b0;
        mem_ready  = 1'b0;
        unique case (state)
            ST_ACCESS: begin
                sram_en    = 1'b1;
                sram_we    = we_q;
                sram_addr  = addr_q;
                sram_wdata = wdata_q;
            end
            ST_DONE: begin
                if_ready  = (grant_q == GRANT_IF);
                mem_ready = (grant_q == GRANT_MEM);
            end
            default: ;
        endcase
    end

    // Request fields are captured only at the grant edge; later changes on the
    // requester inputs have no effect until the FSM is back in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q    <= GRANT_IF;
            last_grant <= GRANT_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else if (start) begin
            grant_q    <= pick;
            last_grant <= pick;
            if (pick == GRANT_MEM) begin
                we_q    <= mem_we;
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
            end else begin
                we_q    <= 1'b0;
                addr_q  <= if_addr;
                wdata_q <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (state == ST_ACCESS && cnt_zero && !we_q) begin
            rdata <= sram_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (WAIT_CYCLES=2): a per-cycle vector table for
// single reads/writes, plus hand sequences for reset abort, dropped request and ties.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] rdata;
    logic        sram_en;
    logic        sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .WAIT_CYCLES(2),
        .ADDR_W     (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ready  (if_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .rdata     (rdata),
        .sram_en   (sram_en),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        mem_req;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [31:0] sram_rdata;
        logic        en;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        if_rdy;
        logic        mem_rdy;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req     = 1'b0;
        if_addr    = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        sram_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_sram_en"}, 32'(sram_en), 32'h0);
        check({tag, "_sram_we"}, 32'(sram_we), 32'h0);
        check({tag, "_sram_addr"}, sram_addr, 32'h0);
        check({tag, "_sram_wdata"}, sram_wdata, 32'h0);
        check({tag, "_if_ready"}, 32'(if_ready), 32'h0);
        check({tag, "_mem_ready"}, 32'(mem_ready), 32'h0);
    endtask

    initial begin
        // Cycle-by-cycle: IF read of 0x10, MEM write to 0x400, MEM read of 0x404.
        vecs[0]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        32'h0,
                     1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h10,  1'b0, 1'b0, 32'h0,   32'h0,        32'h0,
                     1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 32'h10,  1'b0, 1'b0, 32'h0,   32'h0,        32'h0,
                     1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 32'h10,  1'b0, 1'b0, 32'h0,   32'h0,        32'hE3A00001,
                     1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        32'h0,
                     1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 32'hE3A00001};
        vecs[5]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h400, 32'hDEADBEEF, 32'h0,
                     1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'hE3A00001};
        vecs[6]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h400, 32'hDEADBEEF, 32'h12345678,
                     1'b1, 1'b1, 32'h400, 32'hDEADBEEF, 1'b0, 1'b0, 32'hE3A00001};
        vecs[7]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h400, 32'hDEADBEEF, 32'h12345678,
                     1'b1, 1'b1, 32'h400, 32'hDEADBEEF, 1'b0, 1'b0, 32'hE3A00001};
        vecs[8]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        32'h12345678,
                     1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 32'hE3A00001};
        vecs[9]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h404, 32'h0,        32'h0,
                     1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'hE3A00001};
        vecs[10] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h404, 32'h0,        32'h0,
                     1'b1, 1'b0, 32'h404, 32'h0,        1'b0, 1'b0, 32'hE3A00001};
        vecs[11] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h404, 32'h0,        32'hCAFEF00D,
                     1'b1, 1'b0, 32'h404, 32'h0,        1'b0, 1'b0, 32'hE3A00001};
        vecs[12] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        32'h0,
                     1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 32'hCAFEF00D};
        vecs[13] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        32'h0,
                     1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'hCAFEF00D};

        do_reset();
        check_idle_outputs("reset");
        check("reset_rdata", rdata, 32'h0);

        for (int i = 0; i < 14; i++) begin
            if_req     = vecs[i].if_req;
            if_addr    = vecs[i].if_addr;
            mem_req    = vecs[i].mem_req;
            mem_we     = vecs[i].mem_we;
            mem_addr   = vecs[i].mem_addr;
            mem_wdata  = vecs[i].mem_wdata;
            sram_rdata = vecs[i].sram_rdata;
            #1;
            check($sformatf("v%0d_sram_en", i), 32'(sram_en), 32'(vecs[i].en));
            check($sformatf("v%0d_sram_we", i), 32'(sram_we), 32'(vecs[i].we));
            check($sformatf("v%0d_sram_addr", i), sram_addr, vecs[i].addr);
            check($sformatf("v%0d_sram_wdata", i), sram_wdata, vecs[i].wdata);
            check($sformatf("v%0d_if_ready", i), 32'(if_ready), 32'(vecs[i].if_rdy));
            check($sformatf("v%0d_mem_ready", i), 32'(mem_ready), 32'(vecs[i].mem_rdy));
            check($sformatf("v%0d_rdata", i), rdata, vecs[i].rdata);
            step();
        end

        // Reset during the second ACCESS cycle aborts the read with no ready.
        clear_inputs();
        if_req  = 1'b1;
        if_addr = 32'h30;
        step();
        check("abort_access1_en", 32'(sram_en), 32'h1);
        step();
        check("abort_access2_en", 32'(sram_en), 32'h1);
        sram_rdata = 32'h77777777;
        rst        = 1'b1;
        step();
        rst    = 1'b0;
        if_req = 1'b0;
        check_idle_outputs("abort");
        check("abort_rdata", rdata, 32'h0);
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("abort_after%0d_if_ready", c), 32'(if_ready), 32'h0);
            check($sformatf("abort_after%0d_sram_en", c), 32'(sram_en), 32'h0);
        end

        // MEM read whose request drops after the grant still completes.
        clear_inputs();
        mem_req  = 1'b1;
        mem_addr = 32'h20;
        step();
        mem_req = 1'b0;
        check("drop_access1_addr", sram_addr, 32'h20);
        step();
        sram_rdata = 32'hA5A5A5A5;
        check("drop_access2_en", 32'(sram_en), 32'h1);
        step();
        sram_rdata = 32'h0;
        check("drop_mem_ready", 32'(mem_ready), 32'h1);
        check("drop_rdata", rdata, 32'hA5A5A5A5);
        step();
        check("drop_mem_ready_once", 32'(mem_ready), 32'h0);
        check("drop_idle_en", 32'(sram_en), 32'h0);

        // Both requests held from reset release: MEM, IF, MEM, IF, 4 cycles apart.
        do_reset();
        if_req   = 1'b1;
        if_addr  = 32'h100;
        mem_req  = 1'b1;
        mem_addr = 32'h200;
        for (int c = 0; c < 16; c++) begin
            automatic logic exp_mem_turn = ((c / 4) % 2) == 0;
            automatic logic exp_done     = (c % 4) == 3;
            check($sformatf("tie_c%0d_mem_ready", c), 32'(mem_ready), 32'(exp_done && exp_mem_turn));
            check($sformatf("tie_c%0d_if_ready", c), 32'(if_ready), 32'(exp_done && !exp_mem_turn));
            if ((c % 4) == 1) begin
                check($sformatf("tie_c%0d_sram_addr", c), sram_addr,
                      exp_mem_turn ? 32'h200 : 32'h100);
            end
            step();
        end
        clear_inputs();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
